// File: rtl/fp_stream_pkg.sv
// Shared helpers for flattened float streams carried as one {sign, expo, frac} word.
package fp_stream_pkg;

  // Widest word the helpers handle; callers zero-extend into it and truncate back out.
  localparam int FP_MAX_W = 128;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  // Bit position of the sign field inside a packed word.
  function automatic int SIGN_LSB(input int e, input int f);
    return e + f;
  endfunction

  // Bit position of the exponent field inside a packed word.
  function automatic int EXPO_LSB(input int f);
    return f;
  endfunction

  // Mask of the low n bits of a word.
  function automatic fp_word_t low_mask(input int n);
    return (fp_word_t'(1) << n) - fp_word_t'(1);
  endfunction

  // Packs the three fields into {sign, expo, frac}, right-aligned in an FP_MAX_W word.
  function automatic fp_word_t pack_fp(input int e, input int f, input logic sign,
                                       input logic [63:0] expo, input logic [63:0] frac);
    fp_word_t w;
    w = (fp_word_t'(frac) & low_mask(f))
      | ((fp_word_t'(expo) & low_mask(e)) << EXPO_LSB(f))
      | (fp_word_t'(sign) << SIGN_LSB(e, f));
    return w;
  endfunction

  // Extracts the fraction field, right-aligned.
  function automatic fp_word_t unpack_fp_frac(input int f, input fp_word_t w);
    return w & low_mask(f);
  endfunction

  // Extracts the exponent field, right-aligned.
  function automatic fp_word_t unpack_fp_expo(input int e, input int f, input fp_word_t w);
    return (w >> EXPO_LSB(f)) & low_mask(e);
  endfunction

  // Extracts the sign bit.
  function automatic logic unpack_fp_sign(input int e, input int f, input fp_word_t w);
    return w[SIGN_LSB(e, f)];
  endfunction

endpackage

// File: rtl/fifo_ctrl_cc.sv
// Pointer, occupancy and flag control for a single-clock FWFT FIFO of arbitrary depth.
module fifo_ctrl_cc
  import fp_stream_pkg::*;
#(
  parameter  int depth    = 4,
  parameter  int AFULL_TH = depth - 1,
  localparam int PW       = $clog2(depth),
  localparam int CW       = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          s_valid,
  input  logic          m_ready,
  output logic          s_ready,
  output logic          m_valid,
  output logic          push,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  // Explicit wrap at depth-1 so non-power-of-2 depths index correctly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode; ready ignores m_ready so a full FIFO never accepts in its pop cycle.
  always_comb begin
    s_ready     = (count_q != CW'(depth)) & ~flush & ~reset;
    m_valid     = (count_q != '0);
    push        = s_valid & s_ready;
    pop         = m_valid & m_ready;
    almost_full = (count_q >= CW'(AFULL_TH));
  end

  // Next pointers and occupancy; flush and reset drop any concurrent pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/rvfifo_fp_cc.sv
// Ready/valid FWFT FIFO for a flattened float stream; fields pass through bit-exact.
module rvfifo_fp_cc
  import fp_stream_pkg::*;
#(
  parameter  int depth    = 4,
  parameter  int E        = 8,
  parameter  int F        = 23,
  parameter  int AFULL_TH = depth - 1,
  localparam int CW       = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [F-1:0]  s_port_data_frac,
  input  logic [E-1:0]  s_port_data_expo,
  input  logic          s_port_data_sign,
  input  logic          s_port_valid,
  output logic          s_port_ready,
  output logic [F-1:0]  m_port_data_frac,
  output logic [E-1:0]  m_port_data_expo,
  output logic          m_port_data_sign,
  output logic          m_port_valid,
  input  logic          m_port_ready,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  localparam int W  = 1 + E + F;
  localparam int PW = $clog2(depth);

  logic [W-1:0]  mem_q [depth];
  logic [W-1:0]  wr_word_d;
  logic [W-1:0]  rd_word;
  logic          push;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  fifo_ctrl_cc #(
    .depth    (depth),
    .AFULL_TH (AFULL_TH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .s_valid     (s_port_valid),
    .m_ready     (m_port_ready),
    .s_ready     (s_port_ready),
    .m_valid     (m_port_valid),
    .push        (push),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .almost_full (almost_full)
  );

  // Pack the incoming fields into one storage word.
  always_comb begin
    wr_word_d = W'(pack_fp(E, F, s_port_data_sign,
                           64'(s_port_data_expo), 64'(s_port_data_frac)));
  end

  // Storage array; contents are left untouched by flush and reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wr_word_d;
  end

  // Head word is read combinationally so the output falls through.
  always_comb begin
    rd_word          = mem_q[rd_ptr];
    m_port_data_frac = F'(unpack_fp_frac(F, fp_word_t'(rd_word)));
    m_port_data_expo = E'(unpack_fp_expo(E, F, fp_word_t'(rd_word)));
    m_port_data_sign = unpack_fp_sign(E, F, fp_word_t'(rd_word));
  end

endmodule

// File: tb/tb_rvfifo_fp_cc.sv
module tb_rvfifo_fp_cc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // depth-4 instance
  logic        fl4 = 1'b0, v4 = 1'b0, mr4 = 1'b0;
  logic [31:0] d4 = '0;
  logic        sr4, mv4, af4;
  logic [22:0] m4_frac;
  logic [7:0]  m4_expo;
  logic        m4_sign;
  logic [2:0]  c4;
  logic [31:0] m4;
  assign m4 = {m4_sign, m4_expo, m4_frac};

  rvfifo_fp_cc #(.depth(4), .E(8), .F(23), .AFULL_TH(3)) u4 (
    .clk(clk), .reset(rst), .flush(fl4),
    .s_port_data_frac(d4[22:0]), .s_port_data_expo(d4[30:23]), .s_port_data_sign(d4[31]),
    .s_port_valid(v4), .s_port_ready(sr4),
    .m_port_data_frac(m4_frac), .m_port_data_expo(m4_expo), .m_port_data_sign(m4_sign),
    .m_port_valid(mv4), .m_port_ready(mr4),
    .count(c4), .almost_full(af4)
  );

  // depth-3 instance
  logic        fl3 = 1'b0, v3 = 1'b0, mr3 = 1'b0;
  logic [31:0] d3 = '0;
  logic        sr3, mv3, af3;
  logic [22:0] m3_frac;
  logic [7:0]  m3_expo;
  logic        m3_sign;
  logic [1:0]  c3;
  logic [31:0] m3;
  assign m3 = {m3_sign, m3_expo, m3_frac};

  rvfifo_fp_cc #(.depth(3), .E(8), .F(23)) u3 (
    .clk(clk), .reset(rst), .flush(fl3),
    .s_port_data_frac(d3[22:0]), .s_port_data_expo(d3[30:23]), .s_port_data_sign(d3[31]),
    .s_port_valid(v3), .s_port_ready(sr3),
    .m_port_data_frac(m3_frac), .m_port_data_expo(m3_expo), .m_port_data_sign(m3_sign),
    .m_port_valid(mv3), .m_port_ready(mr3),
    .count(c3), .almost_full(af3)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0h required %0h", nm, act, req);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic        mr;
    logic [31:0] d;
    int          cnt;
    logic        mv;
    logic        sr;
    logic        af;
    logic        chkd;
    logic [31:0] ed;
  } vec_t;

  localparam logic [31:0] W0 = 32'h3F80_0000;
  localparam logic [31:0] W1 = 32'hC049_0FDB;
  localparam logic [31:0] W2 = 32'h7FC0_0001;
  localparam logic [31:0] W3 = 32'h0000_0001;
  localparam logic [31:0] W4 = 32'h8000_0000;
  localparam logic [31:0] W5 = 32'h7F80_0000;

  vec_t tbl[10];
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  initial begin
    int k;
    int pushed;
    int popped;
    logic do_push;
    logic do_pop;

    // Inputs applied in this cycle, expected outputs in the same cycle (before the edge).
    tbl[0] = '{1'b1, 1'b0, W0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, W1, 1, 1'b1, 1'b1, 1'b0, 1'b1, W0};
    tbl[2] = '{1'b1, 1'b0, W2, 2, 1'b1, 1'b1, 1'b0, 1'b1, W0};
    tbl[3] = '{1'b1, 1'b0, W3, 3, 1'b1, 1'b1, 1'b1, 1'b1, W0};
    tbl[4] = '{1'b1, 1'b0, W4, 4, 1'b1, 1'b0, 1'b1, 1'b1, W0};
    tbl[5] = '{1'b1, 1'b0, W4, 4, 1'b1, 1'b0, 1'b1, 1'b1, W0};
    tbl[6] = '{1'b1, 1'b1, W4, 4, 1'b1, 1'b0, 1'b1, 1'b1, W0};
    tbl[7] = '{1'b1, 1'b1, W4, 3, 1'b1, 1'b1, 1'b1, 1'b1, W1};
    tbl[8] = '{1'b1, 1'b0, W5, 3, 1'b1, 1'b1, 1'b1, 1'b1, W2};
    tbl[9] = '{1'b0, 1'b0, W5, 4, 1'b1, 1'b0, 1'b1, 1'b1, W2};

    // Reset behaviour
    rst = 1'b1;
    tick();
    tick();
    chk("rst_sready", sr4, 0);
    chk("rst_mvalid", mv4, 0);
    chk("rst_count", c4, 0);
    chk("rst_afull", af4, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_sready", sr4, 1);

    // Table: first push latency, fill to full, held-off fifth word, start of drain
    for (int i = 0; i < 10; i++) begin
      v4 = tbl[i].v;
      mr4 = tbl[i].mr;
      d4 = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_count", i), 64'(c4), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_mvalid", i), mv4, tbl[i].mv);
      chk($sformatf("tbl%0d_sready", i), sr4, tbl[i].sr);
      chk($sformatf("tbl%0d_afull", i), af4, tbl[i].af);
      if (tbl[i].chkd) chk($sformatf("tbl%0d_data", i), m4, tbl[i].ed);
      if (i == 1) begin
        chk("first_sign", m4_sign, 0);
        chk("first_expo", m4_expo, 8'h7F);
        chk("first_frac", m4_frac, 0);
      end
      tick();
    end

    // Full FIFO streamed with valid = ready = 1 for 10 cycles across pointer wrap
    q4 = {W2, W3, W4, W5};
    k = 0;
    for (int i = 0; i < 10; i++) begin
      v4 = 1'b1;
      mr4 = 1'b1;
      d4 = 32'h4000_0000 + 32'(k);
      #1;
      chk($sformatf("strm%0d_count", i), 64'(c4), 64'(q4.size()));
      chk($sformatf("strm%0d_sready", i), sr4, q4.size() < 4);
      chk($sformatf("strm%0d_mvalid", i), mv4, q4.size() != 0);
      if (q4.size() != 0) chk($sformatf("strm%0d_data", i), m4, q4[0]);
      do_push = q4.size() < 4;
      do_pop = q4.size() > 0;
      if (do_pop) void'(q4.pop_front());
      if (do_push) begin
        q4.push_back(d4);
        k++;
      end
      tick();
    end

    // Drain one word to reach count 2, then flush with a concurrent valid word
    v4 = 1'b0;
    mr4 = 1'b1;
    #1;
    chk("pre_flush_count3", c4, 3);
    tick();
    mr4 = 1'b0;
    fl4 = 1'b1;
    v4 = 1'b1;
    d4 = 32'hDEAD_BEEF;
    #1;
    chk("flush_count2", c4, 2);
    chk("flush_sready", sr4, 0);
    tick();
    fl4 = 1'b0;
    v4 = 1'b0;
    #1;
    chk("post_flush_count", c4, 0);
    chk("post_flush_mvalid", mv4, 0);
    chk("post_flush_afull", af4, 0);
    v4 = 1'b1;
    d4 = 32'h1234_5678;
    tick();
    v4 = 1'b0;
    #1;
    chk("post_flush_push_valid", mv4, 1);
    chk("post_flush_push_data", m4, 32'h1234_5678);
    chk("post_flush_push_count", c4, 1);

    // Mid-stream reset with count = 3
    v4 = 1'b1;
    d4 = 32'h0BAD_F00D;
    tick();
    tick();
    #1;
    chk("pre_rst_count", c4, 3);
    chk("pre_rst_afull", af4, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sready", sr4, 0);
    tick();
    #1;
    chk("mid_rst_count", c4, 0);
    chk("mid_rst_mvalid", mv4, 0);
    chk("mid_rst_afull", af4, 0);
    chk("mid_rst_sready_hold", sr4, 0);
    rst = 1'b0;
    v4 = 1'b0;
    #1;
    chk("after_rst_sready", sr4, 1);
    chk("after_rst_count", c4, 0);
    chk("after_rst_afull", af4, 0);
    tick();

    // depth = 3: 7 pushes and 7 pops interleaved through the 2 -> 0 wrap
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 60 && popped < 7; cyc++) begin
      v3 = (pushed < 7);
      d3 = 32'hA000_0000 + 32'(pushed);
      mr3 = (cyc % 3) != 0;
      #1;
      chk("d3_count", 64'(c3), 64'(q3.size()));
      chk("d3_sready", sr3, q3.size() < 3);
      chk("d3_mvalid", mv3, q3.size() != 0);
      if (mr3 && q3.size() != 0) chk("d3_order", m3, q3[0]);
      do_pop = mr3 && (q3.size() > 0);
      do_push = v3 && (q3.size() < 3);
      if (do_pop) begin
        void'(q3.pop_front());
        popped++;
      end
      if (do_push) begin
        q3.push_back(d3);
        pushed++;
      end
      tick();
    end
    v3 = 1'b0;
    mr3 = 1'b0;
    chk("d3_all_popped", 64'(popped), 7);
    #1;
    chk("d3_final_empty", mv3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
